windowed_watchdog: RTL and testbench
====================================

Name: windowed_watchdog

Overview:
Parametrised windowed watchdog timer, the successor to the basic up/down watchdog counter. It adds a programmable prescaler, timeout, early-service window and pre-timeout warning threshold. Configuration locks once the watchdog starts, and only reset can stop it. Typical placement: the system-control block, driving a fault or reset request toward the SoC reset controller.

Parameters:
CNT_WIDTH, 16, width of the timeout counter and of all threshold fields.
PRESCALE_WIDTH, 8, width of the prescaler divider field.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-high reset.
cfg_we  input  1  load config fields; honoured only in IDLE.
cfg_timeout  input  CNT_WIDTH  terminal count value T.
cfg_window  input  CNT_WIDTH  window-open threshold W; service is legal only when count >= W.
cfg_warn  input  CNT_WIDTH  warning threshold A.
cfg_prescale  input  PRESCALE_WIDTH  divider P; one tick every P+1 clocks.
en  input  1  start request; sampled only in IDLE.
service  input  1  watchdog kick, 1-cycle pulse or level (each high cycle counts as a kick).
count  output  CNT_WIDTH  current tick count.
state  output  2  IDLE=0, RUN=1, FIRED=2.
warn  output  1  pre-timeout warning.
timeout  output  1  watchdog fired (sticky).
early_err  output  1  fired because of an early service (sticky).
cfg_err  output  1  start refused because of an illegal configuration.

Behaviour:
- Reset (async, any state): state=IDLE, count=0, prescaler=0, timeout=0, early_err=0, cfg_err=0, warn=0. Config registers reset to T=all-ones, W=0, A=all-ones, P=0.
- IDLE:
  - cfg_we=1 loads all four config registers on that edge.
  - en=1 with the current registers legal (W <= T and A <= T): next state RUN, count=0, prescaler=0, cfg_err cleared.
  - en=1 with W > T or A > T: stay IDLE, cfg_err=1 until the next legal start or rst.
  - If cfg_we and en are high in the same cycle, the start check uses the newly written values, and the registers are updated as well.
  - service is ignored.
- RUN:
  - cfg_we ignored (locked); en ignored (cannot be disabled).
  - Prescaler increments each clock. A tick occurs in the cycle where prescaler == P, and the prescaler returns to 0 at that edge. With P=0, every clock is a tick.
  - On a tick with count < T: count increments by 1.
  - On a tick with count == T and no legal service: next state FIRED, timeout=1, count holds at T.
  - service=1 with count >= W (legal): count=0, prescaler=0. A legal service takes priority over a coincident firing tick.
  - service=1 with count < W (early): next state FIRED, timeout=1, early_err=1, count holds.
- FIRED: absorbing state; service, en and cfg_we are all ignored; only rst exits.
- warn is registered. It is 1 in the cycle after count >= A in RUN, and cleared on the edge after a legal service (count=0). It reads 0 in IDLE and FIRED.
- Arithmetic: count never wraps; it saturates at T by construction. Comparisons are unsigned, full CNT_WIDTH.
- With W=0, service is always legal.
- With T=0, the first tick without service fires.
- Timing from a start or legal service with no further service: timeout rises (T+1)*(P+1) clocks later.

Test Plan:
1. CNT_WIDTH=8, P=0, T=10, W=4, A=8; start; service when count=5 -> count=0 next cycle, timeout=0, warn stays 0.
2. Same config, no service -> warn=1 the cycle after count=8; timeout=1 and state=FIRED 11 clocks after start; count holds 10; later service, en and cfg_we have no effect.
3. Same config, service at count=2 -> timeout=1, early_err=1, state=FIRED next cycle. Separately, service coincident with the firing tick at count=10 -> count=0, no timeout.
4. P=3, T=10 -> count increments every 4 clocks (count=2 after 8 clocks from start); timeout at 44 clocks with no service.
5. cfg W=12, T=10, en=1 -> cfg_err=1, state stays IDLE. Then write W=4, en=1 -> RUN, cfg_err=0. cfg_we with new T and en=0 in RUN -> no change, counting continues.
6. Assert rst mid-RUN (count=6, warn=0) and again in FIRED -> all outputs 0, state=IDLE immediately (async), config registers back to reset defaults.

Source files
------------

// File: rtl/windowed_watchdog.sv
// Windowed watchdog: prescaled tick counter with early-service window, pre-timeout warning and config lock.
// Latency: count/state/flags update on the clock edge after the cause; warn lags count>=A by one cycle.
// Backpressure: none; service is a kick sampled every clock, en/cfg_we only honoured while idle.
module windowed_watchdog #(
  parameter int CNT_WIDTH      = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [CNT_WIDTH-1:0]      cfg_timeout,
  input  logic [CNT_WIDTH-1:0]      cfg_window,
  input  logic [CNT_WIDTH-1:0]      cfg_warn,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  input  logic                      en,
  input  logic                      service,
  output logic [CNT_WIDTH-1:0]      count,
  output logic [1:0]                state,
  output logic                      warn,
  output logic                      timeout,
  output logic                      early_err,
  output logic                      cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  // Architectural state
  state_t                    state_q,     state_d;
  logic [CNT_WIDTH-1:0]      count_q,     count_d;
  logic [PRESCALE_WIDTH-1:0] presc_q,     presc_d;
  logic                      timeout_q,   timeout_d;
  logic                      early_q,     early_d;
  logic                      cfg_err_q,   cfg_err_d;
  logic                      warn_q,      warn_d;

  // Configuration registers (frozen outside IDLE)
  logic [CNT_WIDTH-1:0]      t_q, t_d;
  logic [CNT_WIDTH-1:0]      w_q, w_d;
  logic [CNT_WIDTH-1:0]      a_q, a_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;

  // Config values the start check sees: a same-cycle write wins over the stored copy
  logic [CNT_WIDTH-1:0]      eff_t, eff_w, eff_a;
  logic                      cfg_ok;

  // Per-cycle run conditions
  logic                      tick;
  logic                      svc_legal;
  logic                      svc_early;
  logic                      at_terminal;

  // Derive the start-legality check and the run-time event flags
  always_comb begin
    eff_t       = cfg_we ? cfg_timeout : t_q;
    eff_w       = cfg_we ? cfg_window  : w_q;
    eff_a       = cfg_we ? cfg_warn    : a_q;
    cfg_ok      = (eff_w <= eff_t) && (eff_a <= eff_t);
    tick        = (presc_q == p_q);
    svc_legal   = service && (count_q >= w_q);
    svc_early   = service && (count_q <  w_q);
    // count can never exceed T, so >= is just a defensive form of ==
    at_terminal = (count_q >= t_q);
  end

  // Next-state and next-register logic for the watchdog FSM
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    timeout_d = timeout_q;
    early_d   = early_q;
    cfg_err_d = cfg_err_q;
    warn_d    = 1'b0;
    t_d       = t_q;
    w_d       = w_q;
    a_d       = a_q;
    p_d       = p_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          t_d = cfg_timeout;
          w_d = cfg_window;
          a_d = cfg_warn;
          p_d = cfg_prescale;
        end
        if (en) begin
          if (cfg_ok) begin
            state_d   = ST_RUN;
            count_d   = '0;
            presc_d   = '0;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (svc_legal) begin
          // A legal kick restarts the whole period, even on a firing tick
          count_d = '0;
          presc_d = '0;
        end else if (svc_early) begin
          // Kick before the window opened: fire, count freezes where it was
          state_d   = ST_FIRED;
          timeout_d = 1'b1;
          early_d   = 1'b1;
        end else begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (at_terminal) begin
              state_d   = ST_FIRED;
              timeout_d = 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
          // Warning only persists while we stay in RUN without a restart
          warn_d = (state_d == ST_RUN) && (count_q >= a_q);
        end
      end

      ST_FIRED: begin
        // Absorbing: only reset leaves this state
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and configuration registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
      early_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      warn_q    <= 1'b0;
      t_q       <= '1;
      w_q       <= '0;
      a_q       <= '1;
      p_q       <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      timeout_q <= timeout_d;
      early_q   <= early_d;
      cfg_err_q <= cfg_err_d;
      warn_q    <= warn_d;
      t_q       <= t_d;
      w_q       <= w_d;
      a_q       <= a_d;
      p_q       <= p_d;
    end
  end

  assign count     = count_q;
  assign state     = state_q;
  assign warn      = warn_q;
  assign timeout   = timeout_q;
  assign early_err = early_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_windowed_watchdog.sv
// Directed bench for windowed_watchdog at CNT_WIDTH=8.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// No handshakes to wait on; every sequence has a fixed cycle length.
module tb_windowed_watchdog;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_timeout;
  logic [7:0] cfg_window;
  logic [7:0] cfg_warn;
  logic [7:0] cfg_prescale;
  logic       en;
  logic       service;
  logic [7:0] count;
  logic [1:0] state;
  logic       warn;
  logic       timeout;
  logic       early_err;
  logic       cfg_err;

  int checks   = 0;
  int failures = 0;

  windowed_watchdog #(
    .CNT_WIDTH      (8),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_timeout  (cfg_timeout),
    .cfg_window   (cfg_window),
    .cfg_warn     (cfg_warn),
    .cfg_prescale (cfg_prescale),
    .en           (en),
    .service      (service),
    .count        (count),
    .state        (state),
    .warn         (warn),
    .timeout      (timeout),
    .early_err    (early_err),
    .cfg_err      (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [7:0] t, input logic [7:0] w,
                         input logic [7:0] a, input logic [7:0] p);
    cfg_we       = 1'b1;
    cfg_timeout  = t;
    cfg_window   = w;
    cfg_warn     = a;
    cfg_prescale = p;
    tick(1);
    cfg_we       = 1'b0;
  endtask

  task automatic start_wd();
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Assert reset between edges and check outputs clear before any clock edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_state"},   state,     0);
    chk({tag, "_count"},   count,     0);
    chk({tag, "_warn"},    warn,      0);
    chk({tag, "_timeout"}, timeout,   0);
    chk({tag, "_early"},   early_err, 0);
    chk({tag, "_cfgerr"},  cfg_err,   0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_timeout = '0; cfg_window = '0;
    cfg_warn = '0; cfg_prescale = '0; en = 1'b0; service = 1'b0;
    tick(2);
    chk("rst_state",   state,     0);
    chk("rst_count",   count,     0);
    chk("rst_warn",    warn,      0);
    chk("rst_timeout", timeout,   0);
    chk("rst_early",   early_err, 0);
    chk("rst_cfgerr",  cfg_err,   0);
    rst = 1'b0;
    tick(1);

    // 1: legal service mid-window restarts the count
    set_cfg(8'd10, 8'd4, 8'd8, 8'd0);
    start_wd();
    chk("t1_state_run", state, 1);
    chk("t1_cnt0",      count, 0);
    tick(5);
    chk("t1_cnt5", count, 5);
    service = 1'b1;
    tick(1);
    service = 1'b0;
    chk("t1_cnt_svc", count,   0);
    chk("t1_timeout", timeout, 0);
    chk("t1_warn",    warn,    0);
    chk("t1_state",   state,   1);
    tick(3);
    chk("t1_cnt_after", count, 3);
    do_reset();

    // 2: no service -> warn then timeout after 11 clocks, then locked
    set_cfg(8'd10, 8'd4, 8'd8, 8'd0);
    start_wd();
    tick(8);
    chk("t2_cnt8",   count, 8);
    chk("t2_warn_0", warn,  0);
    tick(1);
    chk("t2_warn_1", warn, 1);
    tick(1);
    chk("t2_cnt10",    count,   10);
    chk("t2_pre_fire", timeout, 0);
    chk("t2_pre_run",  state,   1);
    tick(1);
    chk("t2_fired",   state,     2);
    chk("t2_timeout", timeout,   1);
    chk("t2_hold",    count,     10);
    chk("t2_warn_f",  warn,      0);
    chk("t2_early",   early_err, 0);
    service = 1'b1; en = 1'b1; cfg_we = 1'b1;
    cfg_timeout = 8'd3; cfg_window = 8'd0; cfg_warn = 8'd0;
    tick(2);
    service = 1'b0; en = 1'b0; cfg_we = 1'b0;
    chk("t2_lock_state",   state,     2);
    chk("t2_lock_timeout", timeout,   1);
    chk("t2_lock_count",   count,     10);
    chk("t2_lock_early",   early_err, 0);
    do_reset();

    // 3a: early service fires with early_err
    set_cfg(8'd10, 8'd4, 8'd8, 8'd0);
    start_wd();
    tick(2);
    service = 1'b1;
    tick(1);
    service = 1'b0;
    chk("t3a_state",   state,     2);
    chk("t3a_timeout", timeout,   1);
    chk("t3a_early",   early_err, 1);
    chk("t3a_hold",    count,     2);
    do_reset();

    // 3b: service coincident with firing tick wins
    set_cfg(8'd10, 8'd4, 8'd8, 8'd0);
    start_wd();
    tick(10);
    chk("t3b_warn_pre", warn, 1);
    service = 1'b1;
    tick(1);
    service = 1'b0;
    chk("t3b_count",   count,   0);
    chk("t3b_timeout", timeout, 0);
    chk("t3b_state",   state,   1);
    chk("t3b_warn",    warn,    0);
    do_reset();

    // 4: prescaler P=3 -> one tick every 4 clocks, timeout at 44
    set_cfg(8'd10, 8'd4, 8'd8, 8'd3);
    start_wd();
    tick(7);
    chk("t4_cnt_c7", count, 1);
    tick(1);
    chk("t4_cnt_c8", count, 2);
    tick(35);
    chk("t4_cnt_c43", count,   10);
    chk("t4_to_c43",  timeout, 0);
    tick(1);
    chk("t4_to_c44",    timeout, 1);
    chk("t4_state_c44", state,   2);
    do_reset();

    // 5: illegal W>T refused, then write+start in one cycle, then lock
    set_cfg(8'd10, 8'd12, 8'd8, 8'd0);
    start_wd();
    chk("t5_cfgerr", cfg_err, 1);
    chk("t5_idle",   state,   0);
    cfg_we = 1'b1; cfg_timeout = 8'd10; cfg_window = 8'd4;
    cfg_warn = 8'd8; cfg_prescale = 8'd0; en = 1'b1;
    tick(1);
    cfg_we = 1'b0; en = 1'b0;
    chk("t5_run",       state,   1);
    chk("t5_cfgerr_0",  cfg_err, 0);
    chk("t5_cnt0",      count,   0);
    cfg_we = 1'b1; cfg_timeout = 8'd3; cfg_prescale = 8'd2;
    tick(1);
    cfg_we = 1'b0;
    tick(5);
    chk("t5_lock_cnt",   count, 6);
    chk("t5_lock_state", state, 1);
    tick(4);
    chk("t5_lock_pre", timeout, 0);
    tick(1);
    chk("t5_lock_fire", timeout, 1);
    do_reset();
    set_cfg(8'd10, 8'd0, 8'd11, 8'd0);
    start_wd();
    chk("t5_a_cfgerr", cfg_err, 1);
    chk("t5_a_idle",   state,   0);
    async_reset("t5_rst");

    // 6: async reset mid-RUN and in FIRED, then defaults
    set_cfg(8'd10, 8'd4, 8'd8, 8'd0);
    start_wd();
    tick(6);
    chk("t6_cnt6",  count, 6);
    chk("t6_warn0", warn,  0);
    async_reset("t6_run");
    set_cfg(8'd10, 8'd4, 8'd8, 8'd0);
    start_wd();
    tick(2);
    service = 1'b1;
    tick(1);
    service = 1'b0;
    chk("t6_early_pre", early_err, 1);
    async_reset("t6_fired");
    start_wd();
    chk("t6_def_run",    state,   1);
    chk("t6_def_cfgerr", cfg_err, 0);
    service = 1'b1;
    tick(1);
    service = 1'b0;
    chk("t6_def_svc_state", state,   1);
    chk("t6_def_svc_to",    timeout, 0);
    tick(20);
    chk("t6_def_cnt20", count,   20);
    chk("t6_def_warn",  warn,    0);
    chk("t6_def_to",    timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
